sevenseg_scan_driver: RTL and testbench
=======================================

// Module: sevenseg_scan_driver
// PURPOSE
//  Consumes the 16-bit packed BCD word from the binary-to-BCD stage
//  ({thousands,hundreds,tens,ones}, 4 bits each) and drives a 4-digit
//  common-anode seven-segment display by time-multiplexing the digits.
//  Shadow-latches new values on a valid strobe and commits them only at
//  frame boundaries, so a digit never shows a mix of old and new values.
// PARAMETERS
//  REFRESH_DIV  100_000  clk cycles per digit slot (>=2); 1 kHz/digit @100 MHz
//  BLANK_LZ     1        1 = blank leading zeros; digit 0 is never blanked
// PORTS
//  clk        in   1   system clock, rising edge
//  rst_n      in   1   reset, asynchronous, active-low
//  bcd_in     in   16  packed BCD word from the converter
//  bcd_valid  in   1   1-cycle strobe: capture bcd_in into the shadow register
//  dp_in      in   4   decimal-point enables, bit k = digit k, active-high
//  an         out  4   digit anodes, active-low, an[0] = ones digit
//  seg        out  7   segments, active-low, seg[0]=a ... seg[6]=g
//  dp         out  1   decimal point, active-low
//  frame_tick out  1   1-cycle pulse on the cycle a frame commit occurs
// BEHAVIOUR
//  Reset: one clock; reset is asynchronous and active-low (clk, rst_n).
//   While rst_n=0: div=0, idx=0, shadow=0, disp=0, an=4'b1111,
//   seg=7'h7F, dp=1, frame_tick=0.
//  Divider: div counts 0..REFRESH_DIV-1 and wraps to 0. On the wrap cycle,
//   idx advances 0->1->2->3->0.
//  Capture: bcd_valid=1 loads shadow<=bcd_in. No backpressure; a later
//   strobe overwrites an uncommitted shadow.
//  Commit: on the edge where idx wraps 3->0, disp<=(bcd_valid ? bcd_in
//   : shadow), and frame_tick=1 for that one cycle. A strobe coinciding
//   with the commit is displayed in the frame that is starting.
//  Outputs: an, seg and dp are registered from (idx, disp, dp_in). They
//   lag idx by exactly one clk, so the first cycle after reset release
//   drives digit 0 of disp=0.
//  Anodes: an = ~(1<<idx). If the current digit is blanked, an=4'b1111,
//   seg=7'h7F and dp=1 for the whole slot.
//  Blanking (BLANK_LZ=1): digit k>0 is blanked when nibble k and all
//   higher nibbles are 0. dp_in[k]=1 overrides blanking for that digit.
//  Decode (active-low, g..a): 0=1000000, 1=1111001, 2=0100100, 3=0110000,
//   4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
//   Nibbles A-F display "-" (7'b0111111).
//  dp = ~dp_in[idx], sampled live (not shadowed).
//  Reset mid-frame: all state returns to reset values immediately. The
//   scan restarts at digit 0, and any uncommitted shadow value is lost.
// TESTING (REFRESH_DIV=4, BLANK_LZ=1 unless stated)
//  1 Reset: hold rst_n=0 -> an=1111, seg=7F, dp=1. Release -> next clk
//    an=1110, seg=1000000; an=1101 first appears 4 clks later, blanked
//    as 1111.
//  2 Scan: bcd_valid with 16'h1234 -> after frame_tick, an cycles
//    1110/1101/1011/0111, 4 clks each, with seg 0011001/0110000/
//    0100100/1111001.
//  3 Leading zeros: 16'h0050 -> digit0 "0", digit1 "5" (0010010),
//    digits 2-3 an=1111. Repeat with BLANK_LZ=0 -> digits 2-3 show "0".
//  4 No tearing: strobe 16'h0999 while idx=1 of a frame showing 16'h1234
//    -> digits 2,3 still show 2,1 in that frame; 0999 appears from the
//    next frame_tick. Strobe on the commit cycle -> shown in that frame.
//  5 Invalid/dp: 16'h00A7, dp_in=4'b0100 -> digit1 "-" (0111111),
//    digit2 lit as "0" with dp=0, digit3 blanked.
//  6 Reset mid-op: drop rst_n during idx=2 -> outputs reach reset values
//    without a clk edge. After release, the display shows 0 until a new
//    strobe and a frame commit.

Source files
------------

// File: rtl/sevenseg_scan_driver.sv
// sevenseg_scan_driver
// Time-multiplexes a packed 4-digit BCD word onto a common-anode
// seven-segment display. New words are shadow-latched on bcd_valid and
// only committed to the displayed copy when the scan wraps from digit 3
// to digit 0, so a frame never mixes old and new digits. All display
// outputs are registered and lag the scan index by one clock.

module sevenseg_scan_driver #(
  parameter int REFRESH_DIV = 100_000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bcd_in,
  input  logic        bcd_valid,
  input  logic [3:0]  dp_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int              DIV_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  // Active-low segment pattern (g..a); anything outside 0-9 shows a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'd0:    pat = 7'b1000000;
      4'd1:    pat = 7'b1111001;
      4'd2:    pat = 7'b0100100;
      4'd3:    pat = 7'b0110000;
      4'd4:    pat = 7'b0011001;
      4'd5:    pat = 7'b0010010;
      4'd6:    pat = 7'b0000010;
      4'd7:    pat = 7'b1111000;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0010000;
      default: pat = 7'b0111111;
    endcase
    return pat;
  endfunction

  logic [DIV_W-1:0] div_r;
  logic [1:0]       idx_r;
  logic [15:0]      shadow_r;
  logic [15:0]      disp_r;

  logic             wrap_s;
  logic             commit_s;
  logic [3:0]       nib_s;
  logic             upper_zero_s;
  logic             blank_s;
  logic [3:0]       an_next_s;
  logic [6:0]       seg_next_s;
  logic             dp_next_s;

  assign wrap_s   = (div_r == DIV_LAST);
  assign commit_s = wrap_s && (idx_r == 2'd3);

  // Slot divider and digit index; the index steps once per slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r <= '0;
      idx_r <= 2'd0;
    end else if (wrap_s) begin
      div_r <= '0;
      idx_r <= idx_r + 2'd1;
    end else begin
      div_r <= div_r + DIV_W'(1);
    end
  end

  // Shadow capture (latest strobe wins) and frame-boundary commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_r <= 16'h0000;
      disp_r   <= 16'h0000;
    end else begin
      if (bcd_valid) begin
        shadow_r <= bcd_in;
      end
      if (commit_s) begin
        // A strobe landing on the commit edge bypasses the shadow so it is
        // shown in the frame that is just starting.
        disp_r <= bcd_valid ? bcd_in : shadow_r;
      end
    end
  end

  // Select the current nibble and decide whether it is a blanked leading zero.
  always_comb begin
    nib_s        = 4'h0;
    upper_zero_s = 1'b0;
    case (idx_r)
      2'd0: begin
        nib_s        = disp_r[3:0];
        upper_zero_s = 1'b0;
      end
      2'd1: begin
        nib_s        = disp_r[7:4];
        upper_zero_s = (disp_r[15:4] == 12'h000);
      end
      2'd2: begin
        nib_s        = disp_r[11:8];
        upper_zero_s = (disp_r[15:8] == 8'h00);
      end
      2'd3: begin
        nib_s        = disp_r[15:12];
        upper_zero_s = (disp_r[15:12] == 4'h0);
      end
      default: begin
        nib_s        = 4'h0;
        upper_zero_s = 1'b0;
      end
    endcase
    blank_s = (BLANK_LZ == 1'b1) && upper_zero_s && !dp_in[idx_r];
  end

  // Next values for the display pins; a blanked slot turns everything off.
  always_comb begin
    an_next_s  = 4'b1111;
    seg_next_s = 7'h7F;
    dp_next_s  = 1'b1;
    if (blank_s) begin
      an_next_s  = 4'b1111;
      seg_next_s = 7'h7F;
      dp_next_s  = 1'b1;
    end else begin
      an_next_s  = ~(4'b0001 << idx_r);
      seg_next_s = seg_decode(nib_s);
      dp_next_s  = ~dp_in[idx_r];
    end
  end

  // Output registers, one clock behind the scan index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an         <= 4'b1111;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_next_s;
      seg        <= seg_next_s;
      dp         <= dp_next_s;
      frame_tick <= commit_s;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed testbench for sevenseg_scan_driver (REFRESH_DIV=4). A second
// instance with BLANK_LZ=0 shares all inputs for the leading-zero case.

module tb_sevenseg_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] bcd_in;
  logic        bcd_valid;
  logic [3:0]  dp_in;
  logic [3:0]  an,  an2;
  logic [6:0]  seg, seg2;
  logic        dp,  dp2;
  logic        frame_tick, frame_tick2;

  int checks = 0;
  int errors = 0;

  logic [3:0] obs_an  [16];
  logic [6:0] obs_seg [16];
  logic       obs_dp  [16];
  logic       obs_ft  [16];
  logic [3:0] obs_an2 [16];
  logic [6:0] obs_seg2[16];

  sevenseg_scan_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .bcd_valid(bcd_valid),
    .dp_in(dp_in), .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
  );

  sevenseg_scan_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .bcd_valid(bcd_valid),
    .dp_in(dp_in), .an(an2), .seg(seg2), .dp(dp2), .frame_tick(frame_tick2)
  );

  always #5 clk = ~clk;

  task automatic strobe(input logic [15:0] v);
    @(negedge clk);
    bcd_in    = v;
    bcd_valid = 1'b1;
    @(posedge clk);
    #1 bcd_valid = 1'b0;
  endtask

  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic capture_frame();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      obs_an[i]   = an;
      obs_seg[i]  = seg;
      obs_dp[i]   = dp;
      obs_ft[i]   = frame_tick;
      obs_an2[i]  = an2;
      obs_seg2[i] = seg2;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bcd_in = 16'h0000; bcd_valid = 1'b0; dp_in = 4'b0000;
    repeat (3) @(negedge clk);
    checks++;
    if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1 || frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: an=%b seg=%b dp=%b ft=%b, expected 1111 1111111 1 0", an, seg, dp, frame_tick);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (an !== 4'b1110 || seg !== 7'b1000000 || dp !== 1'b1) begin
        errors++;
        $display("FAIL reset_digit0 cyc%0d: an=%b seg=%b dp=%b, expected 1110 1000000 1", c, an, seg, dp);
      end
    end
    @(negedge clk);
    checks++;
    if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1) begin
      errors++;
      $display("FAIL reset_digit1_blank: an=%b seg=%b dp=%b, expected 1111 1111111 1", an, seg, dp);
    end
  endtask

  task automatic test_scan();
    bit ok;
    logic [3:0] ea[4];
    logic [6:0] es[4];
    int ft_cnt;
    ea = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    es = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
    strobe(16'h1234);
    wait_tick(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL scan_tick: frame_tick=0 after 40 clks, expected 1"); end
    capture_frame();
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (obs_an[4*k+c] !== ea[k] || obs_seg[4*k+c] !== es[k] || obs_dp[4*k+c] !== 1'b1) begin
          errors++;
          $display("FAIL scan d%0d c%0d: an=%b seg=%b dp=%b, expected an=%b seg=%b dp=1",
                   k, c, obs_an[4*k+c], obs_seg[4*k+c], obs_dp[4*k+c], ea[k], es[k]);
        end
      end
    ft_cnt = 0;
    for (int i = 0; i < 16; i++) ft_cnt += int'(obs_ft[i]);
    checks++;
    if (ft_cnt != 1 || obs_ft[15] !== 1'b1) begin
      errors++;
      $display("FAIL scan_ft_period: ticks=%0d last=%b, expected 1 tick on cycle 16", ft_cnt, obs_ft[15]);
    end
  endtask

  task automatic test_decode_68();
    bit ok;
    logic [3:0] ea[4];
    logic [6:0] es[4];
    ea = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    es = '{7'b1000000, 7'b1000000, 7'b0000010, 7'b0000000};
    strobe(16'h8600);
    wait_tick(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL dec_tick: frame_tick=0 after 40 clks, expected 1"); end
    capture_frame();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs_an[4*k+1] !== ea[k] || obs_seg[4*k+1] !== es[k]) begin
        errors++;
        $display("FAIL dec8600 d%0d: an=%b seg=%b, expected an=%b seg=%b", k, obs_an[4*k+1], obs_seg[4*k+1], ea[k], es[k]);
      end
    end
  endtask

  task automatic test_leading_zeros();
    bit ok;
    logic [3:0] ea[4], ea2[4];
    logic [6:0] es[4], es2[4];
    ea  = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
    es  = '{7'b1000000, 7'b0010010, 7'h7F, 7'h7F};
    ea2 = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    es2 = '{7'b1000000, 7'b0010010, 7'b1000000, 7'b1000000};
    strobe(16'h0050);
    wait_tick(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL lz_tick: frame_tick=0 after 40 clks, expected 1"); end
    capture_frame();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs_an[4*k+2] !== ea[k] || obs_seg[4*k+2] !== es[k]) begin
        errors++;
        $display("FAIL lz_blank d%0d: an=%b seg=%b, expected an=%b seg=%b", k, obs_an[4*k+2], obs_seg[4*k+2], ea[k], es[k]);
      end
      checks++;
      if (obs_an2[4*k+2] !== ea2[k] || obs_seg2[4*k+2] !== es2[k]) begin
        errors++;
        $display("FAIL lz_noblank d%0d: an=%b seg=%b, expected an=%b seg=%b", k, obs_an2[4*k+2], obs_seg2[4*k+2], ea2[k], es2[k]);
      end
    end
  endtask

  task automatic test_no_tearing();
    bit ok;
    logic [3:0] ea[4], eb[4];
    logic [6:0] es[4], eb_s[4], ec_s[4];
    ea   = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    es   = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
    eb   = '{4'b1110, 4'b1101, 4'b1011, 4'b1111};
    eb_s = '{7'b0010000, 7'b0010000, 7'b0010000, 7'h7F};
    ec_s = '{7'b0100100, 7'b0011001, 7'h7F, 7'h7F};
    strobe(16'h1234);
    wait_tick(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL tear_tick: frame_tick=0 after 40 clks, expected 1"); end
    // Record the 1234 frame while a new word arrives during digit 1.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      obs_an[i]  = an;
      obs_seg[i] = seg;
      obs_ft[i]  = frame_tick;
      if (i == 4) begin bcd_in = 16'h0999; bcd_valid = 1'b1; end
      if (i == 5) bcd_valid = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs_an[4*k+3] !== ea[k] || obs_seg[4*k+3] !== es[k]) begin
        errors++;
        $display("FAIL tear_old d%0d: an=%b seg=%b, expected an=%b seg=%b", k, obs_an[4*k+3], obs_seg[4*k+3], ea[k], es[k]);
      end
    end
    checks++;
    if (obs_ft[15] !== 1'b1) begin
      errors++;
      $display("FAIL tear_tick2: frame_tick=%b, expected 1", obs_ft[15]);
    end
    capture_frame();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs_an[4*k] !== eb[k] || obs_seg[4*k] !== eb_s[k]) begin
        errors++;
        $display("FAIL tear_new d%0d: an=%b seg=%b, expected an=%b seg=%b", k, obs_an[4*k], obs_seg[4*k], eb[k], eb_s[k]);
      end
    end
    // Now positioned on a commit cycle's tick; strobe on the next commit edge.
    repeat (15) @(negedge clk);
    bcd_in = 16'h0042; bcd_valid = 1'b1;
    @(posedge clk);
    #1 bcd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (frame_tick !== 1'b1) begin
      errors++;
      $display("FAIL commit_strobe_tick: frame_tick=%b, expected 1", frame_tick);
    end
    capture_frame();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs_an[4*k] !== eb[k] && k < 2 || k >= 2 && obs_an[4*k] !== 4'b1111 || obs_seg[4*k] !== ec_s[k]) begin
        errors++;
        $display("FAIL commit_strobe d%0d: an=%b seg=%b, expected seg=%b", k, obs_an[4*k], obs_seg[4*k], ec_s[k]);
      end
    end
  endtask

  task automatic test_invalid_dp();
    bit ok;
    logic [3:0] ea[4];
    logic [6:0] es[4];
    logic       ed[4];
    ea = '{4'b1110, 4'b1101, 4'b1011, 4'b1111};
    es = '{7'b1111000, 7'b0111111, 7'b1000000, 7'h7F};
    ed = '{1'b1, 1'b1, 1'b0, 1'b1};
    dp_in = 4'b0100;
    strobe(16'h00A7);
    wait_tick(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL dp_tick: frame_tick=0 after 40 clks, expected 1"); end
    capture_frame();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs_an[4*k+1] !== ea[k] || obs_seg[4*k+1] !== es[k] || obs_dp[4*k+1] !== ed[k]) begin
        errors++;
        $display("FAIL inv_dp d%0d: an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                 k, obs_an[4*k+1], obs_seg[4*k+1], obs_dp[4*k+1], ea[k], es[k], ed[k]);
      end
    end
    dp_in = 4'b0000;
  endtask

  task automatic test_reset_midop();
    bit ok;
    strobe(16'h1234);
    wait_tick(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_mid_tick: frame_tick=0 after 40 clks, expected 1"); end
    strobe(16'h5555);
    repeat (8) @(negedge clk);
    checks++;
    if (an !== 4'b1011 || seg !== 7'b0100100) begin
      errors++;
      $display("FAIL rst_mid_pre: an=%b seg=%b, expected 1011 0100100", an, seg);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1 || frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async: an=%b seg=%b dp=%b ft=%b, expected 1111 1111111 1 0", an, seg, dp, frame_tick);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (an !== 4'b1110 || seg !== 7'b1000000) begin
      errors++;
      $display("FAIL rst_mid_restart: an=%b seg=%b, expected 1110 1000000", an, seg);
    end
    wait_tick(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_mid_tick2: frame_tick=0 after 40 clks, expected 1"); end
    capture_frame();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k == 0 && (obs_an[0] !== 4'b1110 || obs_seg[0] !== 7'b1000000) ||
          k > 0 && (obs_an[4*k] !== 4'b1111 || obs_seg[4*k] !== 7'h7F)) begin
        errors++;
        $display("FAIL rst_mid_shadow_lost d%0d: an=%b seg=%b, expected zero display", k, obs_an[4*k], obs_seg[4*k]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_scan();
    test_decode_68();
    test_leading_zeros();
    test_no_tearing();
    test_invalid_dp();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
